// File: rtl/bram_dp_bytelane_if.sv
// rtl/bram_dp_bytelane_if.sv - write/read port bundle for bram_dp_bytelane
//
// Purpose: groups the write port A, read port B and busy flag of the RAM.
// Signals:
//   busy        RAM is running its post-reset clear sweep
//   wea         byte-lane write enables (bit i covers dina[8i+7:8i])
//   addra/dina  write address / write data
//   reb/addrb   read enable / read address
//   doutb       read data
//   doutb_valid doutb carries the result of a read
// Modports: master = requester side, slave = RAM side.
interface bram_dp_bytelane_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic                      busy;
    logic [DATA_WIDTH/8-1:0]   wea;
    logic [ADDR_WIDTH-1:0]     addra;
    logic [DATA_WIDTH-1:0]     dina;
    logic                      reb;
    logic [ADDR_WIDTH-1:0]     addrb;
    logic [DATA_WIDTH-1:0]     doutb;
    logic                      doutb_valid;

    modport master (
        input  busy, doutb, doutb_valid,
        output wea, addra, dina, reb, addrb
    );

    modport slave (
        output busy, doutb, doutb_valid,
        input  wea, addra, dina, reb, addrb
    );
endinterface

// File: rtl/bram_dp_bytelane.sv
// rtl/bram_dp_bytelane.sv - simple dual-port block RAM with byte-lane writes
//
// Purpose: one write port with per-byte enables, one read port with read
// enable and valid flag, selectable read-during-write behaviour, optional
// output register and a clear sweep after reset.
// Ports:
//   clka  clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   bram_dp_bytelane_if.slave (busy, wea, addra, dina, reb, addrb,
//         doutb, doutb_valid)
module bram_dp_bytelane #(
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   ADDR_WIDTH     = 14,
    parameter int                   OUT_REG        = 0,
    parameter int                   RDW_MODE       = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic               clka,
    input  logic               rstn,
    bram_dp_bytelane_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_next;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_state   <= RESET_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = S_READY;
                end
            end
            default: begin
                w_state_next = S_READY;
            end
        endcase
    end

    logic                    w_busy;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [NB-1:0]           w_wr_en;
    logic                    w_rd_en;

    // The sweep borrows the write port; user requests are dropped meanwhile.
    assign w_busy    = (r_state == S_CLEAR);
    assign w_wr_addr = w_busy ? r_clr_cnt   : bus.addra;
    assign w_wr_data = w_busy ? CLEAR_VALUE : bus.dina;
    assign w_wr_en   = w_busy ? {NB{1'b1}}  : bus.wea;
    assign w_rd_en   = !w_busy && bus.reb;
    assign bus.busy  = w_busy;

    // Write-first forwarding: remember which lanes were overwritten at the
    // read address in the read cycle, and with what data.
    logic [NB-1:0]           r_fwd_mask;
    logic [DATA_WIDTH-1:0]   r_fwd_data;
    logic                    r_v1;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_fwd_mask <= '0;
            r_fwd_data <= '0;
            r_v1       <= 1'b0;
        end else begin
            r_v1 <= w_rd_en;
            if (w_rd_en) begin
                r_fwd_mask <= ((RDW_MODE != 0) && (bus.addra == bus.addrb)) ? bus.wea : '0;
                r_fwd_data <= bus.dina;
            end
        end
    end

    logic [DATA_WIDTH-1:0]   w_rd_word;

    // One array per byte lane keeps each lane a plain read-first BRAM.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clka) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr] <= w_wr_data[8*i +: 8];
            end
            if (w_rd_en) begin
                r_q <= r_mem[bus.addrb];
            end
        end

        assign w_rd_word[8*i +: 8] = r_fwd_mask[i] ? r_fwd_data[8*i +: 8] : r_q;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                    r_v2;
        logic [DATA_WIDTH-1:0]   r_dout2;

        always_ff @(posedge clka or negedge rstn) begin
            if (!rstn) begin
                r_v2    <= 1'b0;
                r_dout2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dout2 <= w_rd_word;
                end
            end
        end

        assign bus.doutb       = r_dout2;
        assign bus.doutb_valid = r_v2;
    end else begin : g_out_direct
        // The BRAM output latch cannot be reset, so doutb is forced to zero
        // until the first read after reset has landed.
        logic r_hold1;

        always_ff @(posedge clka or negedge rstn) begin
            if (!rstn) begin
                r_hold1 <= 1'b0;
            end else if (w_rd_en) begin
                r_hold1 <= 1'b1;
            end
        end

        assign bus.doutb       = r_hold1 ? w_rd_word : '0;
        assign bus.doutb_valid = r_v1;
    end
endmodule

// File: tb/tb_bram_dp_bytelane.sv
// tb/tb_bram_dp_bytelane.sv - self-checking bench for bram_dp_bytelane
module tb_bram_dp_bytelane;
    localparam logic [31:0] CLR = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bram_dp_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
    bram_dp_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

    // dut0: latency 1, read-first.  dut1: latency 2, write-first.
    bram_dp_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(0),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR))
        dut0 (.clka(clk), .rstn(rstn), .bus(bus0));
    bram_dp_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .RDW_MODE(1),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR))
        dut1 (.clka(clk), .rstn(rstn), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [31:0] m_mem [16];
    int          m_busy_left;
    logic        m_v0, m_v1a, m_v1;
    logic [31:0] m_d0, m_d1a, m_d1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] wea, input logic [3:0] aa, input logic [31:0] din,
                         input logic reb, input logic [3:0] ab);
        bus0.wea = wea; bus0.addra = aa; bus0.dina = din; bus0.reb = reb; bus0.addrb = ab;
        bus1.wea = wea; bus1.addra = aa; bus1.dina = din; bus1.reb = reb; bus1.addrb = ab;
    endtask

    task automatic idle();
        drive(4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic model_reset();
        m_v0 = 0; m_v1a = 0; m_v1 = 0;
        m_d0 = 0; m_d1a = 0; m_d1 = 0;
        for (int a = 0; a < 16; a++) m_mem[a] = CLR;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output shortly after the edge.
    task automatic step();
        logic        rd;
        logic [31:0] old_w, new_w;
        @(posedge clk);
        rd = 1'b0; old_w = '0; new_w = '0;
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            rd = bus0.reb;
            old_w = m_mem[bus0.addrb];
            new_w = old_w;
            for (int l = 0; l < 4; l++) begin
                if (bus0.wea[l]) begin
                    if (bus0.addra == bus0.addrb) new_w[8*l +: 8] = bus0.dina[8*l +: 8];
                    m_mem[bus0.addra][8*l +: 8] = bus0.dina[8*l +: 8];
                end
            end
        end
        m_v1 = m_v1a;
        if (m_v1a) m_d1 = m_d1a;
        m_v1a = rd;
        if (rd) m_d1a = new_w;
        m_v0 = rd;
        if (rd) m_d0 = old_w;
        #1;
        chk("busy0",  {31'b0, bus0.busy}, {31'b0, m_busy_left > 0});
        chk("busy1",  {31'b0, bus1.busy}, {31'b0, m_busy_left > 0});
        chk("valid0", {31'b0, bus0.doutb_valid}, {31'b0, m_v0});
        chk("dout0",  bus0.doutb, m_d0);
        chk("valid1", {31'b0, bus1.doutb_valid}, {31'b0, m_v1});
        chk("dout1",  bus1.doutb, m_d1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy0",  {31'b0, bus0.busy}, 32'd1);
        chk("rst_busy1",  {31'b0, bus1.busy}, 32'd1);
        chk("rst_valid0", {31'b0, bus0.doutb_valid}, 32'd0);
        chk("rst_valid1", {31'b0, bus1.doutb_valid}, 32'd0);
        chk("rst_dout0",  bus0.doutb, 32'h0);
        chk("rst_dout1",  bus1.doutb, 32'h0);
    endtask

    // Counts clocks until busy drops, bounded.
    task automatic sweep_len(output int n);
        n = 0;
        while (bus0.busy && n < 40) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]  wea;
        logic [3:0]  addra;
        logic [31:0] dina;
        logic        reb;
        logic [3:0]  addrb;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{4'hF, 4'd3, 32'h11223344, 1'b0, 4'd0, 32'h0, 32'h0};
        vecs[1] = '{4'h5, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0, 32'h0, 32'h0};
        vecs[2] = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'h11BB33DD, 32'h11BB33DD};
        vecs[3] = '{4'hF, 4'd5, 32'h00000000, 1'b0, 4'd0, 32'h0, 32'h0};
        vecs[4] = '{4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h00000000, 32'h0000FFFF};
        vecs[5] = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 32'h0000FFFF, 32'h0000FFFF};

        // Reset state
        idle();
        model_reset();
        m_busy_left = 16;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;

        // Clear sweep length and contents
        sweep_len(n);
        chk("sweep_len", n, 32'd16);
        for (int a = 0; a < 16; a++) begin
            drive(4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            step();
            chk("clr_valid", {31'b0, bus0.doutb_valid}, 32'd1);
            chk("clr_word",  bus0.doutb, CLR);
        end
        idle();
        step();
        step();

        // Byte lanes and read-during-write table
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].wea, vecs[i].addra, vecs[i].dina, vecs[i].reb, vecs[i].addrb);
            step();
            if (vecs[i].reb) chk($sformatf("vec%0d_rdw0", i), bus0.doutb, vecs[i].exp0);
            idle();
            step();
            if (vecs[i].reb) chk($sformatf("vec%0d_rdw1", i), bus1.doutb, vecs[i].exp1);
        end

        // Latency / throughput of the registered-output instance
        for (int a = 0; a < 4; a++) begin
            drive(4'hF, 4'(a), 32'(10 + a), 1'b0, 4'h0);
            step();
        end
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) drive(4'h0, 4'h0, 32'h0, 1'b1, 4'(c - 1));
            else idle();
            step();
            chk($sformatf("lat_valid_c%0d", c), {31'b0, bus1.doutb_valid},
                {31'b0, (c >= 2 && c <= 5)});
            if (c >= 2) chk($sformatf("lat_data_c%0d", c), bus1.doutb, (c <= 5) ? 32'(8 + c) : 32'd13);
        end

        // Randomized traffic, frequent same-address collisions
        for (int k = 0; k < 400; k++) begin
            logic [3:0] aa, ab;
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                  aa, $urandom, 1'($urandom_range(0, 1)), ab);
            step();
        end
        idle();
        step();
        step();

        // Reset mid-sweep, requests ignored while busy
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        m_busy_left = 16;
        #2;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;
        repeat (7) step();
        rstn = 1'b0;
        model_reset();
        #2;
        check_reset_outputs();
        #2;
        rstn = 1'b1;
        m_busy_left = 16;
        drive(4'hF, 4'd2, 32'hDEADBEEF, 1'b1, 4'd2);
        sweep_len(n);
        chk("sweep_len_restart", n, 32'd16);
        drive(4'h0, 4'h0, 32'h0, 1'b1, 4'd2);
        step();
        chk("busy_write_ignored", bus0.doutb, CLR);
        idle();
        step();
        chk("busy_write_ignored1", bus1.doutb, CLR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_dp_bytelane.md
Name: bram_dp_bytelane

Overview:
- Parametrised simple-dual-port block RAM: one write port (A) with byte-lane enables, one read port (B) with read enable and valid flag.
- Successor to the fixed 32-bit program/data RAM used behind the Cortex-M0 bus bridge.
- Adds the following over that RAM:
  - configurable data width
  - selectable read-during-write behaviour
  - optional output pipeline register
  - hardware clear sequence after reset, since BRAM contents cannot be async-reset.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 14, address width; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old word; 1 = write-first (new bytes forwarded).
- CLEAR_ON_RESET, 1, 1 = sweep memory with CLEAR_VALUE after reset; 0 = no sweep, contents undefined.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written during the sweep.

Ports:
- clka  in  1  clock, all logic rising edge
- rstn  in  1  asynchronous active-low reset
- busy  out  1  high while clear sweep runs; ports A/B ignored
- wea  in  NB  byte-lane write enables, bit i covers dina[8i+7:8i]
- addra  in  ADDR_WIDTH  write address
- dina  in  DATA_WIDTH  write data
- reb  in  1  read enable
- addrb  in  ADDR_WIDTH  read address
- doutb  out  DATA_WIDTH  read data
- doutb_valid  out  1  doutb holds data for a read issued at latency L earlier

Behaviour:
- Reset values (async, rstn=0):
  - doutb = 0, doutb_valid = 0.
  - Pipeline valid bits cleared.
  - busy = 1 if CLEAR_ON_RESET, else 0.
  - Clear counter = 0.
  - Memory array is not reset.
- FSM states:
  - CLEAR: entered on reset when CLEAR_ON_RESET=1.
    - Each cycle writes CLEAR_VALUE to counter address; counter += 1.
    - When counter = DEPTH-1, write it and go to READY next cycle.
    - Sweep takes exactly DEPTH cycles after rstn rises.
    - busy drops on the edge that enters READY.
  - READY: normal operation. Terminal state until next reset.
  - CLEAR_ON_RESET=0: FSM starts in READY.
- In CLEAR, wea/reb are ignored: no user write, doutb_valid stays 0.
- Reset asserted mid-sweep: sweep restarts from address 0 after release.
- Write:
  - In READY, each byte lane with wea[i]=1 is written to mem[addra] at the clock edge.
  - Other lanes are unchanged.
  - wea = 0 means no write.
- Read:
  - In READY with reb=1, mem[addrb] is sampled at the edge.
  - OUT_REG=0: doutb and doutb_valid=1 appear after the edge (latency 1).
  - OUT_REG=1: one extra register stage (latency 2).
- When no read completes, doutb_valid=0 and doutb holds its previous value, not zeroed.
- Back-to-back reads: one result per cycle, full throughput, no bubbles.
- Read-during-write, reb=1, wea!=0, addra=addrb in the same cycle:
  - RDW_MODE=0: doutb = word before the write.
  - RDW_MODE=1: each lane with wea[i]=1 returns dina lane i; other lanes return the old word.
  - Different addresses: no interaction.
- Address wrap: none needed; all addresses in 0..DEPTH-1 are valid.
- Infer as a block RAM with per-lane write always-blocks. Only the forwarding mux and valid/pipeline registers sit outside the array.

Test Plan:
- Clear sweep (ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5):
  - release rstn -> busy=1 for exactly 16 cycles, then 0.
  - Read all 16 addresses -> every word = A5A5A5A5, doutb_valid=1 one cycle after each reb.
- Byte lanes:
  - write 32'h11223344 wea=4'hF to addr 3.
  - Then write 32'hAABBCCDD wea=4'b0101 to addr 3.
  - Read addr 3 -> 32'h11BB33DD.
- Read-during-write at addr 5 (old word 32'h00000000), wea=4'b0011, dina=32'hFFFFFFFF, same-cycle read:
  - RDW_MODE=0 -> 32'h00000000.
  - RDW_MODE=1 -> 32'h0000FFFF.
  - Either mode: the next read of addr 5 -> 32'h0000FFFF.
- Latency/throughput (OUT_REG=1):
  - reb high for 4 consecutive cycles on addrs 0..3 holding 10,11,12,13.
  - -> doutb_valid high cycles 2..5, data 10,11,12,13 in order.
  - reb low afterwards -> valid 0, doutb holds 13.
- Reset mid-sweep and ignored requests:
  - pulse rstn low at sweep cycle 7 -> busy stays high, sweep restarts, total 16 cycles after second release.
  - Write issued during busy (addr 2, 32'hDEADBEEF) -> addr 2 still reads CLEAR_VALUE.
